instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters: IMEM_DEPTH, default 256, instruction memory size in 32-bit words (power of 2).
REQ-002 Parameters: RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-003 One clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-004 Ports, in order:
- clock  input  1  rising-edge clock.
- reset  input  1  async active-high reset.
- stall  input  1  downstream not ready; hold the current fetch.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target PC for redirect_valid.
- load_en  input  1  instruction memory write strobe.
- load_addr  input  log2(IMEM_DEPTH)  word address for the load.
- load_data  input  32  instruction word to store.
- instruction_code  output  32  fetched instruction, feeds processor instruction_code.
- pc_out  output  32  PC of instruction_code.
- inst_valid  output  1  instruction_code is a fresh, executable instruction.
- misaligned_fault  output  1  sticky; a redirect target had pc[1:0] != 0.

Function
REQ-005 FSM states: BOOT, RUN, FAULT; reset enters BOOT.
REQ-006 BOOT lasts exactly one cycle with inst_valid=0 and issues the read at RESET_PC; next state is RUN.
REQ-007 In RUN with stall=0 and redirect_valid=0: instruction_code <= mem[pc[log2(IMEM_DEPTH)+1:2]], pc_out <= pc, inst_valid <= 1, pc <= pc+4.
REQ-008 Fetch latency: one cycle; the word at PC X is on instruction_code the cycle after the PC register holds X.
REQ-009 In RUN with stall=1 and redirect_valid=0: pc, instruction_code, pc_out and inst_valid hold their values.
REQ-010 redirect_valid=1 has priority over stall.
REQ-011 On a redirect with redirect_pc[1:0]==0: pc <= redirect_pc and inst_valid <= 0 for exactly one cycle (a bubble). Fetch then resumes from redirect_pc.
REQ-012 On a redirect with redirect_pc[1:0]!=0: misaligned_fault <= 1 and inst_valid <= 0, then enter FAULT.
REQ-013 FAULT is left only by reset. In FAULT, pc holds and all redirects and stalls are ignored.
REQ-014 PC addition is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-015 The memory index uses only pc[log2(IMEM_DEPTH)+1:2]; PCs beyond IMEM_DEPTH*4 alias modulo the memory size.
REQ-016 load_en writes mem[load_addr] <= load_data at the clock edge, in any state including FAULT.
REQ-017 A same-cycle read and write to the same word returns the old data (read-before-write).
REQ-018 redirect_valid asserted in BOOT is honoured, with the same rules as in RUN.

Reset
REQ-019 On reset assertion, immediately: pc=RESET_PC, instruction_code=32'h0000_0013 (NOP), pc_out=RESET_PC, inst_valid=0, misaligned_fault=0, state=BOOT.
REQ-020 Reset does not clear memory contents.
REQ-021 Reset asserted mid-stall or mid-redirect discards the pending operation; fetch restarts at RESET_PC.

Structure
REQ-022 A shared package riscv_pkg holds the FSM state enum, NOP_INSTR=32'h0000_0013, and XLEN=32.
REQ-023 The instruction storage is one sub-module, imem_sync: synchronous read port plus synchronous write port, depth IMEM_DEPTH.
REQ-024 The FSM, PC register and output registers reside in instr_fetch_unit.

Verification
REQ-025 Scenario: preload mem[0..3]={A,B,C,D}, release reset -> inst_valid=0 for 1 cycle, then A,B,C,D with pc_out 0,4,8,C on consecutive cycles.
REQ-026 Scenario: stall=1 for 3 cycles while B is presented -> B, pc_out=4 and inst_valid=1 held; C follows on the cycle after stall drops.
REQ-027 Scenario: redirect_pc=0x20 together with stall=1 -> one bubble (inst_valid=0), then mem[8] with pc_out=0x20.
REQ-028 Scenario: redirect_pc=0x22 -> misaligned_fault=1 and inst_valid=0 permanently; a later redirect to 0x40 is ignored until reset.
REQ-029 Scenario: IMEM_DEPTH=256, run to pc=0x3FC then 0x400 -> instruction_code returns mem[255] then mem[0].
REQ-030 Scenario: assert reset asynchronously mid-cycle while in RUN at pc=0x10 -> outputs reach their reset values before the next edge; a load written before reset is still readable afterwards.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice: data width, NOP encoding,
// fetch FSM states and a small alignment helper.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // RV32I canonical NOP (addi x0, x0, 0)
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // PC increment for sequential 32-bit instructions
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    // True when the two low byte-offset bits of an address select a whole word
    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return byte_off == 2'b00;
    endfunction

endpackage

// File: rtl/imem_sync.sv
// Instruction memory: one synchronous read port and one synchronous write port.
// The read data register is resettable and holds when rd_en is low, so it can
// serve directly as the fetch unit's instruction output register.
module imem_sync
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH      = 256,
    parameter logic [XLEN-1:0] RESET_DATA = NOP_INSTR,
    localparam int unsigned    ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]   rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data
);

    logic [XLEN-1:0] mem [DEPTH];

    // Write port; contents are deliberately not touched by reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port; sampling before the write lands gives read-before-write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= RESET_DATA;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, BOOT/RUN/FAULT control and a one-cycle
// synchronous instruction memory. instruction_code comes straight from the
// memory's read register; pc_out and inst_valid are registered here.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    localparam int unsigned    ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [XLEN-1:0]   load_data,
    output logic [XLEN-1:0]   instruction_code,
    output logic [XLEN-1:0]   pc_out,
    output logic              inst_valid,
    output logic              misaligned_fault
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;

    logic            fetch_c;
    logic            redirect_c;
    logic            misalign_c;
    logic [ADDR_W-1:0] fetch_idx_c;

    // Word index into the memory; higher PC bits alias modulo the depth
    assign fetch_idx_c = pc[ADDR_W+1:2];

    // Decode this cycle's action; redirect outranks stall, BOOT never stalls
    always_comb begin
        fetch_c    = 1'b0;
        redirect_c = 1'b0;
        misalign_c = 1'b0;
        if (state != FAULT) begin
            if (redirect_valid) begin
                if (is_word_aligned(redirect_pc[1:0])) begin
                    redirect_c = 1'b1;
                end else begin
                    misalign_c = 1'b1;
                end
            end else if (!stall || state == BOOT) begin
                fetch_c = 1'b1;
            end
        end
    end

    // FSM, PC and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= BOOT;
            pc               <= RESET_PC;
            pc_out           <= RESET_PC;
            inst_valid       <= 1'b0;
            misaligned_fault <= 1'b0;
        end else begin
            case (state)
                BOOT, RUN: begin
                    if (misalign_c) begin
                        misaligned_fault <= 1'b1;
                        inst_valid       <= 1'b0;
                        state            <= FAULT;
                    end else if (redirect_c) begin
                        pc         <= redirect_pc;
                        inst_valid <= 1'b0;
                        state      <= RUN;
                    end else if (fetch_c) begin
                        pc_out     <= pc;
                        pc         <= pc + INSTR_BYTES;
                        inst_valid <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: begin
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

    // Instruction storage; loads are accepted in every state
    imem_sync #(
        .DEPTH      (IMEM_DEPTH),
        .RESET_DATA (NOP_INSTR)
    ) u_imem (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (fetch_c),
        .rd_addr (fetch_idx_c),
        .rd_data (instruction_code),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit (IMEM_DEPTH=256, RESET_PC=0).
module tb_instr_fetch_unit;

    localparam int unsigned AW = 8;
    localparam int unsigned NVEC = 22;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = 32'h0;
    logic [31:0]   instruction_code;
    logic [31:0]   pc_out;
    logic          inst_valid;
    logic          misaligned_fault;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          stall;
        logic          rv;
        logic [31:0]   rpc;
        logic          ld;
        logic [AW-1:0] laddr;
        logic [31:0]   ldata;
        logic [31:0]   e_instr;
        logic [31:0]   e_pc;
        logic          e_valid;
        logic          e_fault;
    } vec_t;

    vec_t vecs [NVEC];

    instr_fetch_unit #(
        .IMEM_DEPTH (256),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .load_en          (load_en),
        .load_addr        (load_addr),
        .load_data        (load_data),
        .instruction_code (instruction_code),
        .pc_out           (pc_out),
        .inst_valid       (inst_valid),
        .misaligned_fault (misaligned_fault)
    );

    always #5 clock = ~clock;

    // Preloaded image: word i holds C0DE00ii
    function automatic logic [31:0] w(input int i);
        return {16'hC0DE, 8'h00, 8'(i)};
    endfunction

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                                input logic ld, input logic [AW-1:0] la, input logic [31:0] lda,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic ev, input logic ef);
        vec_t v;
        v.stall = s; v.rv = rv; v.rpc = rpc; v.ld = ld; v.laddr = la; v.ldata = lda;
        v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_fault = ef;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                             input logic ev, input logic ef);
        check32({tag, ".instr"}, instruction_code, ei);
        check32({tag, ".pc_out"}, pc_out, ep);
        check32({tag, ".valid"}, 32'(inst_valid), 32'(ev));
        check32({tag, ".fault"}, 32'(misaligned_fault), 32'(ef));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(0),   32'h0,         1, 0);
        vecs[1]  = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(1),   32'h4,         1, 0);
        vecs[2]  = mk(1, 0, 32'h0,         0, 8'd0, 32'h0,         w(1),   32'h4,         1, 0);
        vecs[3]  = mk(1, 0, 32'h0,         0, 8'd0, 32'h0,         w(1),   32'h4,         1, 0);
        vecs[4]  = mk(1, 0, 32'h0,         0, 8'd0, 32'h0,         w(1),   32'h4,         1, 0);
        vecs[5]  = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(2),   32'h8,         1, 0);
        vecs[6]  = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(3),   32'hC,         1, 0);
        vecs[7]  = mk(1, 1, 32'h20,        0, 8'd0, 32'h0,         w(3),   32'hC,         0, 0);
        vecs[8]  = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(8),   32'h20,        1, 0);
        vecs[9]  = mk(0, 0, 32'h0,         1, 8'd9, 32'h1234_5678, w(9),   32'h24,        1, 0);
        vecs[10] = mk(0, 1, 32'h3F8,       0, 8'd0, 32'h0,         w(9),   32'h24,        0, 0);
        vecs[11] = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(254), 32'h3F8,       1, 0);
        vecs[12] = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(255), 32'h3FC,       1, 0);
        vecs[13] = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(0),   32'h400,       1, 0);
        vecs[14] = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(1),   32'h404,       1, 0);
        vecs[15] = mk(0, 1, 32'hFFFF_FFFC, 0, 8'd0, 32'h0,         w(1),   32'h404,       0, 0);
        vecs[16] = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(255), 32'hFFFF_FFFC, 1, 0);
        vecs[17] = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(0),   32'h0,         1, 0);
        vecs[18] = mk(0, 1, 32'h22,        0, 8'd0, 32'h0,         w(0),   32'h0,         0, 1);
        vecs[19] = mk(0, 1, 32'h40,        1, 8'd5, 32'hDEAD_BEEF, w(0),   32'h0,         0, 1);
        vecs[20] = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         w(0),   32'h0,         0, 1);
        vecs[21] = mk(1, 0, 32'h0,         0, 8'd0, 32'h0,         w(0),   32'h0,         0, 1);

        // Preload the whole memory while reset is held
        #1;
        for (int i = 0; i < 256; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = w(i);
            tick();
        end
        load_en = 1'b0;
        check_out("reset", 32'h0000_0013, 32'h0, 1'b0, 1'b0);

        // Release reset: the BOOT cycle shows no valid instruction
        reset = 1'b0;
        #1;
        check_out("boot", 32'h0000_0013, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < int'(NVEC); i++) begin
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            load_en        = vecs[i].ld;
            load_addr      = vecs[i].laddr;
            load_data      = vecs[i].ldata;
            tick();
            check_out($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_pc,
                      vecs[i].e_valid, vecs[i].e_fault);
        end
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; load_en = 1'b0;

        // Reset leaves FAULT and clears the sticky flag immediately
        reset = 1'b1;
        #1;
        check_out("fault_reset", 32'h0000_0013, 32'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        // Redirect during BOOT; mem[9] now holds the word written in RUN
        redirect_valid = 1'b1; redirect_pc = 32'h24;
        tick();
        check_out("boot_redir", 32'h0000_0013, 32'h0, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        tick();
        check_out("after_boot_redir", 32'h1234_5678, 32'h24, 1'b1, 1'b0);

        // Word loaded while in FAULT survived reset
        redirect_valid = 1'b1; redirect_pc = 32'h14;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_out("fault_load", 32'hDEAD_BEEF, 32'h14, 1'b1, 1'b0);

        // Redirect to 0x10 then stall; async reset mid-cycle discards it
        redirect_valid = 1'b1; redirect_pc = 32'h10; stall = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check_out("redir10", 32'hDEAD_BEEF, 32'h14, 1'b0, 1'b0);
        tick();
        check_out("redir10_stall", 32'hDEAD_BEEF, 32'h14, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check_out("async_reset", 32'h0000_0013, 32'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        stall = 1'b0;
        tick();
        check_out("restart0", w(0), 32'h0, 1'b1, 1'b0);
        tick();
        check_out("restart1", w(1), 32'h4, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
